// File: rtl/uart_rx_pkg.sv
// Shared UART types and constants: receiver FSM state encoding and default baud divisors.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_e;

    // Clocks per 16x oversampling tick at 50 MHz
    localparam int DVSR_19200 = 163;
    localparam int DVSR_9600  = 326;

endpackage

// File: rtl/baud_rate_gen.sv
// Free-running oversampling tick generator; one-cycle tick every DVSR clocks.
module baud_rate_gen #(
    parameter int DVSR      = 163,
    parameter int DVSR_BITS = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    logic [DVSR_BITS-1:0] cnt_q, cnt_d;
    logic                 wrap;

    assign wrap   = (cnt_q == DVSR_BITS'(DVSR - 1));
    assign o_tick = wrap;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (wrap) cnt_d = '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver: synchronises i_rx, deserialises LSB-first frames and
// emits a one-cycle write strobe (with framing-error flag) for the downstream FIFO.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int DVSR      = DVSR_19200,
    parameter int DVSR_BITS = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    output logic            o_rx_done_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_frame_err
);

    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic tick;

    baud_rate_gen #(
        .DVSR      (DVSR),
        .DVSR_BITS (DVSR_BITS)
    ) u_baud (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (tick)
    );

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    logic sync1_q, rx_s_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            rx_s_q  <= sync1_q;
        end
    end

    rx_state_e       state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == SW'(7)) begin
                        // A start bit that is high again at mid-bit was a glitch
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) state_d = STOP;
                        else                      n_d = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        dout_d  = b_q;
                        done_d  = 1'b1;
                        ferr_d  = !rx_s_q;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_dout         = dout_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_err    = ferr_q;

endmodule
